// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the segment scan controller.
// Optional leading-zero blanking is enabled with the SEG_LEADING_ZERO_BLANK_EN macro.
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;

  // All anodes off (active-low), wide enough for the largest digit count.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Width of the shared dwell/blank down-counter.
  function automatic int cnt_width(input int refresh_div, input int blank_cycles);
    int m;
    m = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready load port carrying one nibble per digit.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_load_buf.sv
// seg_load_buf: pending/active double buffer behind the valid/ready load port.
// The display only ever reads the active copy; pending moves across on xfer.
module seg_load_buf
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_scan_ctrl_if.slave          load_if,
  input  logic                    xfer,
  output logic [4*NUM_DIGITS-1:0] disp_value
);

  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic                    pending_full;

  // Value seen by the digit latched on this edge: a transfer edge must already
  // show the new data so the frame starting there is not torn.
  assign disp_value = (xfer && pending_full) ? pending : active;

  // Load capture and pending->active transfer; load_ready mirrors !pending_full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending           <= '0;
      active            <= '0;
      pending_full      <= 1'b0;
      load_if.load_ready <= 1'b1;
    end else if (xfer && pending_full) begin
      active            <= pending;
      pending_full      <= 1'b0;
      load_if.load_ready <= 1'b1;
    end else if (load_if.load_valid && load_if.load_ready) begin
      pending           <= load_if.load_data;
      pending_full      <= 1'b1;
      load_if.load_ready <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode digits through
// one shared 7-segment decoder, with dwell and blanking intervals.
// Define SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always shown).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scan_en,
  seg_scan_ctrl_if.slave                load_if,
  output logic [3:0]                    dec_bin,
  output logic                          dec_en,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ANODE_OFF[NUM_DIGITS-1:0];
  localparam logic [CNT_W-1:0]      SHOW_LD = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLNK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      LAST_IX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic                    xfer;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    suppress;

  // Transfer whenever idle, or at the frame boundary (BLANK->SHOW into digit 0).
  assign xfer = (state == IDLE) ||
                (scan_en && (state == BLANK) && (cnt == '0) && (digit_idx == '0));

  seg_load_buf #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_load_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_if   (load_if),
    .xfer      (xfer),
    .disp_value(disp_value)
  );

  assign cur_nib = disp_value[{digit_idx, 2'b00} +: 4];
  assign an_sel  = ~(NUM_DIGITS'(1) << digit_idx);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Leading zero: this nibble and all higher ones are zero, and not digit 0.
  assign suppress = (digit_idx != '0) && ((disp_value >> {digit_idx, 2'b00}) == '0);
`else
  assign suppress = 1'b0;
`endif

  // Scan FSM with the shared down-counter; all display outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      an_n       <= AN_OFF;
      dec_en     <= 1'b0;
      dec_bin    <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!scan_en) begin
        state     <= IDLE;
        cnt       <= '0;
        digit_idx <= '0;
        an_n      <= AN_OFF;
        dec_en    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= BLANK;
            cnt       <= BLNK_LD;
            digit_idx <= '0;
            an_n      <= AN_OFF;
            dec_en    <= 1'b0;
          end
          BLANK: begin
            if (cnt == '0) begin
              state   <= SHOW;
              cnt     <= SHOW_LD;
              dec_bin <= cur_nib;
              dec_en  <= !suppress;
              an_n    <= suppress ? AN_OFF : an_sel;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SHOW: begin
            if (cnt == '0) begin
              state      <= BLANK;
              cnt        <= BLNK_LD;
              an_n       <= AN_OFF;
              dec_en     <= 1'b0;
              digit_idx  <= (digit_idx == LAST_IX) ? '0 : digit_idx + 1'b1;
              frame_done <= (digit_idx == LAST_IX);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            an_n  <= AN_OFF;
            dec_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler that shares one 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds a double-buffered digit value register and cycles through the digits with a programmable dwell time and inter-digit blanking.
- Drives the decoder's binary input and enable, plus active-low anode selects.
- Sits between the value producer (valid/ready load port) and the decoder plus display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clk cycles each digit is shown (>=2).
- BLANK_CYCLES, 4, clk cycles all anodes are off between digits (>=1); anti-ghosting.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  1 = scanning; 0 = display dark.
- load_valid  in  1  producer has a new display value.
- load_ready  out  1  pending buffer empty, value accepted this cycle if load_valid.
- load_data  in  4*NUM_DIGITS  nibble k = digit k, where digit 0 is the least significant nibble.
- dec_bin  out  4  nibble to decoder binary input.
- dec_en  out  1  decoder enable.
- an_n  out  NUM_DIGITS  anode selects, active-low, one-hot-low when showing.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current or next digit.
- frame_done  out  1  one-cycle pulse when the last digit's SHOW phase ends.

Behaviour:
- Reset (async assert, sync release) sets: an_n all 1, dec_en 0, dec_bin 0, digit_idx 0, load_ready 1, frame_done 0, FSM = IDLE, active and pending registers 0, pending_full 0.
- All outputs are registered.
- Load handshake:
  - load_ready = !pending_full.
  - On load_valid && load_ready, capture load_data into pending and set pending_full next cycle.
  - load_data is ignored when load_ready = 0.
- Transfer from pending to active, clearing pending_full:
  - In IDLE, one cycle after pending_full is set.
  - Otherwise, only on a frame boundary, i.e. the BLANK->SHOW transition into digit 0. This makes updates tear-free.
  - A load in the same cycle as a transfer is impossible, because load_ready is 0 while pending_full is set.
- FSM states IDLE, SHOW, BLANK; one shared down-counter cnt.
  - IDLE: an_n all 1, dec_en 0. When scan_en = 1, go to BLANK with digit_idx = 0 and cnt = BLANK_CYCLES-1.
  - BLANK: an_n all 1, dec_en 0. When cnt = 0, go to SHOW with cnt = REFRESH_DIV-1. On that same edge:
    - dec_bin <= active nibble[digit_idx]
    - dec_en <= 1
    - an_n[digit_idx] <= 0
  - SHOW: outputs held. When cnt = 0:
    - Go to BLANK with cnt = BLANK_CYCLES-1.
    - digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
    - frame_done pulses if the old digit_idx was NUM_DIGITS-1.
- Digit k's anode is low for exactly REFRESH_DIV cycles. Anodes of consecutive digits are never low in the same cycle.
- Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES).
- scan_en deasserted in any state: next cycle go to IDLE with an_n all 1, dec_en 0, digit_idx 0. The partial frame is abandoned with no frame_done. Pending data is kept.
- Mid-operation reset: outputs go to reset values immediately (async). Pending and active data are lost.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined, a digit is suppressed while showing if:
  - its active nibble is 0,
  - every higher-index nibble is 0, and
  - its index is not 0.
- Suppressed means dec_en = 0 and its anode stays high during its SHOW slot. Slot timing and frame_done are unchanged.
- When undefined, all digits always display.

Decomposition:
- Package seg_scan_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t
  - localparam function for the counter width, $clog2(max(REFRESH_DIV, BLANK_CYCLES))
  - an ANODE_OFF constant
- Sub-module seg_load_buf implements the pending/active double buffer with the valid/ready port and the transfer strobe input.
- The FSM and counter stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1):
- Reset, then check: an_n=4'b1111, dec_en=0, load_ready=1, digit_idx=0. Assert rst_n low mid-SHOW -> outputs return to reset values in the same cycle.
- Load 16'h12AF with scan_en=1 -> active = 16'h12AF. Expected sequence:
  - an_n=1110 with dec_bin=F for 4 cycles
  - 1 blank cycle (an_n=1111)
  - an_n=1101 with dec_bin=A
  - then 1011 with 2, then 0111 with 1
  - frame_done pulses once per 20-cycle frame
- Mid-frame load of 16'h3456 -> load_ready=0 until the digit 0 boundary; the current frame still shows 12AF; the next frame shows 6,5,4,3; load_ready returns to 1.
- Second load_valid while pending_full -> not accepted; data is displayed only after load_ready=1 and a fresh handshake.
- scan_en dropped during digit 2 SHOW -> next cycle an_n=1111, dec_en=0, digit_idx=0, no frame_done. Re-assert -> 1 blank cycle, then digit 0.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 have dec_en=0 and an_n high during their slots; digit 1 shows 5; digit 0 shows 0.
